// File: rtl/vga_pkg.sv
// Shared constants for the VGA pong design: pad motion and button debounce timing.
package vga_pkg;

   localparam int unsigned DEBOUNCE_CYCLES = 650_000;  // 10 ms at 65 MHz
   localparam int unsigned PAD_VELOCITY    = 4;

endpackage : vga_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser followed by a debounce FSM with a stability counter.
module debounce_channel #(
   parameter int unsigned DEBOUNCE_CYCLES = 650_000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic stable
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // State and counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the counter only runs in the WAIT states and is cleared on every exit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         STABLE_LO: begin
            if (s2) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!s2) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (s2) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode: the accepted level is held high until a release is confirmed
   always_comb begin
      stable = 1'b0;
      if (state_q == STABLE_HI || state_q == WAIT_LO) begin
         stable = 1'b1;
      end
   end

endmodule : debounce_channel

// File: rtl/pad_input_conditioner.sv
// Per-player up/down button conditioner: debounce, up+down conflict resolution, press pulses.
module pad_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = vga_pkg::DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic up,
   output logic down,
   output logic up_press,
   output logic down_press
);

   logic stable_up;
   logic stable_down;
   logic up_n;
   logic down_n;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_up_ch (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_up_raw),
      .stable  (stable_up)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_down_ch (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_down_raw),
      .stable  (stable_down)
   );

   // Holding both buttons means neither direction
   always_comb begin
      up_n   = stable_up & ~stable_down;
      down_n = stable_down & ~stable_up;
   end

   // Levels and rising-edge pulses registered together so the pulse aligns with the level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up         <= 1'b0;
         down       <= 1'b0;
         up_press   <= 1'b0;
         down_press <= 1'b0;
      end else begin
         up         <= up_n;
         down       <= down_n;
         up_press   <= up_n & ~up;
         down_press <= down_n & ~down;
      end
   end

endmodule : pad_input_conditioner

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner with an 8-cycle debounce window.
module tb_pad_input_conditioner;

   localparam int unsigned N   = 8;
   localparam int unsigned LAT = N + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up_raw = 1'b0;
   logic btn_down_raw = 1'b0;
   logic up, down, up_press, down_press;

   int vectors = 0;
   int miscompares = 0;

   pad_input_conditioner #(
      .DEBOUNCE_CYCLES (N)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .up           (up),
      .down         (down),
      .up_press     (up_press),
      .down_press   (down_press)
   );

   always #5 clk = ~clk;

   // Release both buttons and let everything settle back to idle
   task automatic go_idle();
      @(negedge clk);
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      vectors++;
      if ({up, down, up_press, down_press} !== 4'b0000) begin
         miscompares++;
         $display("FAIL idle: outs=%b expected 0000", {up, down, up_press, down_press});
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({up, down, up_press, down_press} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_hold: outs=%b expected 0000", {up, down, up_press, down_press});
      end
      @(negedge clk);
      rst = 1'b0;
      // bring up to accepted-high, then press down and reset mid-cycle
      btn_up_raw = 1'b1;
      repeat (LAT + 1) @(posedge clk);
      #1;
      vectors++;
      if (up !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pre_up: up=%b expected 1", up);
      end
      @(negedge clk);
      btn_down_raw = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({up, down, up_press, down_press} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_async: outs=%b expected 0000", {up, down, up_press, down_press});
      end
      @(negedge clk);
      btn_down_raw = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c >= int'(LAT)) || up_press !== (c == int'(LAT)) || down !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release c=%0d: up=%b press=%b down=%b expected up=%b press=%b down=0",
                     c, up, up_press, down, c >= int'(LAT), c == int'(LAT));
         end
      end
      go_idle();
   endtask

   task automatic test_clean_press();
      @(negedge clk);
      btn_up_raw = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c >= int'(LAT)) || up_press !== (c == int'(LAT)) || down !== 1'b0
             || down_press !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_press c=%0d: up=%b press=%b down=%b expected up=%b press=%b down=0",
                     c, up, up_press, down, c >= int'(LAT), c == int'(LAT));
         end
      end
      @(negedge clk);
      btn_up_raw = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c < int'(LAT)) || up_press !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_release c=%0d: up=%b press=%b expected up=%b press=0",
                     c, up, up_press, c < int'(LAT));
         end
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int seg = 0; seg < 10; seg++) begin
         @(negedge clk);
         btn_down_raw = (seg % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({up, down, up_press, down_press} !== 4'b0000) begin
               miscompares++;
               $display("FAIL bounce_toggle seg=%0d c=%0d: outs=%b expected 0000",
                        seg, c, {up, down, up_press, down_press});
            end
         end
      end
      @(negedge clk);
      btn_down_raw = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         if (down_press) pulses++;
         vectors++;
         if (down !== (c >= int'(LAT)) || up !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_settle c=%0d: down=%b up=%b expected down=%b up=0",
                     c, down, up, c >= int'(LAT));
         end
      end
      vectors++;
      if (pulses !== 1) begin
         miscompares++;
         $display("FAIL bounce_pulses: got %0d expected 1", pulses);
      end
      go_idle();
   endtask

   task automatic test_conflict();
      @(negedge clk);
      btn_up_raw = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      vectors++;
      if (up !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_pre: up=%b expected 1", up);
      end
      @(negedge clk);
      btn_down_raw = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c < int'(LAT)) || down !== 1'b0 || down_press !== 1'b0 || up_press !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_both c=%0d: up=%b down=%b up_p=%b dn_p=%b expected up=%b down=0 pulses=0",
                     c, up, down, up_press, down_press, c < int'(LAT));
         end
      end
      @(negedge clk);
      btn_down_raw = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c >= int'(LAT)) || up_press !== (c == int'(LAT)) || down !== 1'b0
             || down_press !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_release c=%0d: up=%b press=%b down=%b expected up=%b press=%b down=0",
                     c, up, up_press, down, c >= int'(LAT), c == int'(LAT));
         end
      end
      go_idle();
   endtask

   task automatic test_short_glitch();
      @(negedge clk);
      btn_up_raw = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== 1'b0 || up_press !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch c=%0d: up=%b press=%b expected 0 0", c, up, up_press);
         end
         // raw high for N-1 sampling edges; counter peaks at N-1 one edge after s2 first shows it
         if (c == int'(N)) begin
            vectors++;
            if (u_dut.u_up_ch.cnt_q !== 3'd7) begin
               miscompares++;
               $display("FAIL glitch_peak: cnt=%0d expected 7", u_dut.u_up_ch.cnt_q);
            end
         end
         if (c == int'(N) - 2) begin
            @(negedge clk);
            btn_up_raw = 1'b0;
         end
      end
      vectors++;
      if (u_dut.u_up_ch.cnt_q !== 3'd0) begin
         miscompares++;
         $display("FAIL glitch_cnt: cnt=%0d expected 0", u_dut.u_up_ch.cnt_q);
      end
   endtask

   task automatic test_reset_mid_debounce();
      @(negedge clk);
      btn_up_raw = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      vectors++;
      if (u_dut.u_up_ch.cnt_q !== 3'd5) begin
         miscompares++;
         $display("FAIL mid_cnt: cnt=%0d expected 5", u_dut.u_up_ch.cnt_q);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (u_dut.u_up_ch.cnt_q !== 3'd0 || up !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: cnt=%0d up=%b expected 0 0", u_dut.u_up_ch.cnt_q, up);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (up !== (c >= int'(LAT)) || up_press !== (c == int'(LAT))) begin
            miscompares++;
            $display("FAIL mid_release c=%0d: up=%b press=%b expected up=%b press=%b",
                     c, up, up_press, c >= int'(LAT), c == int'(LAT));
         end
         if (c == 2) begin
            vectors++;
            if (u_dut.u_up_ch.cnt_q !== 3'd1) begin
               miscompares++;
               $display("FAIL mid_restart: cnt=%0d expected 1", u_dut.u_up_ch.cnt_q);
            end
         end
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_conflict();
      test_short_glitch();
      test_reset_mid_debounce();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pad_input_conditioner
